// File: rtl/bus_timer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared types and reset constants for the timer bus arbiter.
//               State set depends on BUS_TIMER_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

`ifdef BUS_TIMER_ARBITER_LOCK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;
`endif

    typedef logic master_idx_t;

    // Master 0 wins the first tie after reset.
    localparam master_idx_t RESET_LAST_GRANT = 1'b1;
    localparam master_idx_t RESET_OWNER      = 1'b0;

endpackage
`default_nettype wire

// File: rtl/bus_timer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_arbiter_if
// Description : Master-side and slave-side bus signals of the timer arbiter.
//               Lock inputs exist only with BUS_TIMER_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_timer_arbiter_if #(
    parameter int ADDRESS_WIDTH = 1,
    parameter int DATA_WIDTH    = 32
);
    logic                     m0Enable,     m1Enable;
    logic                     m0Write,      m1Write;
    logic [ADDRESS_WIDTH-1:0] m0Address,    m1Address;
    logic [DATA_WIDTH-1:0]    m0WriteData,  m1WriteData;
    logic [DATA_WIDTH-1:0]    m0ReadData,   m1ReadData;
    logic                     m0Wait,       m1Wait;
`ifdef BUS_TIMER_ARBITER_LOCK_EN
    logic                     m0Lock,       m1Lock;
`endif
    logic                     slaveEnable;
    logic                     slaveWrite;
    logic [ADDRESS_WIDTH-1:0] slaveAddress;
    logic [DATA_WIDTH-1:0]    slaveWriteData;
    logic [DATA_WIDTH-1:0]    slaveReadData;
    logic                     slaveWait;

    // Arbiter view: serves the two masters, drives the timer slave.
    modport slave (
`ifdef BUS_TIMER_ARBITER_LOCK_EN
        input  m0Lock, m1Lock,
`endif
        input  m0Enable, m1Enable, m0Write, m1Write,
        input  m0Address, m1Address, m0WriteData, m1WriteData,
        output m0ReadData, m1ReadData, m0Wait, m1Wait,
        output slaveEnable, slaveWrite, slaveAddress, slaveWriteData,
        input  slaveReadData, slaveWait
    );

    // Environment view: the masters and the timer slave.
    modport master (
`ifdef BUS_TIMER_ARBITER_LOCK_EN
        output m0Lock, m1Lock,
`endif
        output m0Enable, m1Enable, m0Write, m1Write,
        output m0Address, m1Address, m0WriteData, m1WriteData,
        input  m0ReadData, m1ReadData, m0Wait, m1Wait,
        input  slaveEnable, slaveWrite, slaveAddress, slaveWriteData,
        output slaveReadData, slaveWait
    );
endinterface
`default_nettype wire

// File: rtl/bus_timer_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr_select
// Description : Two-way round-robin winner select (combinational).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr_select
    import bus_arbiter_pkg::*;
(
    input  logic        i_req0,
    input  logic        i_req1,
    input  master_idx_t i_last_grant,
    output master_idx_t o_winner,
    output logic        o_any_request
);

    always_comb begin
        o_any_request = i_req0 | i_req1;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_grant;
        end else if (i_req1) begin
            o_winner = 1'b1;
        end else begin
            o_winner = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_timer_arbiter
// Description : Round-robin two-master arbiter in front of the timer slave.
//               BUS_TIMER_ARBITER_LOCK_EN adds the LOCKED state (atomic RMW).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timer_arbiter
    import bus_arbiter_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    bus_timer_arbiter_if.slave   bus
);

    arb_state_t  r_state;
    master_idx_t r_owner;
    master_idx_t r_last_grant;

    master_idx_t w_winner;
    logic        w_any_request;
    logic        w_owner_en;
    logic        w_complete;

    bus_arbiter_rr_select u_rr_select (
        .i_req0        (bus.m0Enable),
        .i_req1        (bus.m1Enable),
        .i_last_grant  (r_last_grant),
        .o_winner      (w_winner),
        .o_any_request (w_any_request)
    );

    assign w_owner_en = r_owner ? bus.m1Enable : bus.m0Enable;
    assign w_complete = (r_state == BUSY) && w_owner_en && !bus.slaveWait;

`ifdef BUS_TIMER_ARBITER_LOCK_EN
    logic w_owner_lock;
    assign w_owner_lock = r_owner ? bus.m1Lock : bus.m0Lock;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= RESET_OWNER;
            r_last_grant <= RESET_LAST_GRANT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_request) begin
                        r_owner <= w_winner;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // A dropped enable abandons the transfer without
                    // counting as a grant for round-robin purposes.
                    if (!w_owner_en) begin
                        r_state <= IDLE;
                    end else if (!bus.slaveWait) begin
                        r_last_grant <= r_owner;
`ifdef BUS_TIMER_ARBITER_LOCK_EN
                        r_state      <= w_owner_lock ? LOCKED : IDLE;
`else
                        r_state      <= IDLE;
`endif
                    end
                end
`ifdef BUS_TIMER_ARBITER_LOCK_EN
                LOCKED: begin
                    if (w_owner_en) begin
                        r_state <= BUSY;
                    end else if (!w_owner_lock) begin
                        r_state <= IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

    // Forwarding is a pure function of state/owner, so IDLE has no
    // combinational path from a request to its wait.
    always_comb begin
        bus.slaveEnable    = 1'b0;
        bus.slaveWrite     = 1'b0;
        bus.slaveAddress   = '0;
        bus.slaveWriteData = '0;
        bus.m0Wait         = 1'b1;
        bus.m1Wait         = 1'b1;
        bus.m0ReadData     = '0;
        bus.m1ReadData     = '0;
        if (r_state == BUSY) begin
            bus.slaveEnable = w_owner_en;
            if (r_owner) begin
                bus.slaveWrite     = bus.m1Write;
                bus.slaveAddress   = bus.m1Address;
                bus.slaveWriteData = bus.m1WriteData;
                bus.m1Wait         = !w_complete;
                bus.m1ReadData     = bus.slaveReadData;
            end else begin
                bus.slaveWrite     = bus.m0Write;
                bus.slaveAddress   = bus.m0Address;
                bus.slaveWriteData = bus.m0WriteData;
                bus.m0Wait         = !w_complete;
                bus.m0ReadData     = bus.slaveReadData;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_timer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_timer_arbiter
// Description : Directed bench for bus_timer_arbiter with a small timer model.
//               Lock steps run only with BUS_TIMER_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_timer_arbiter;

    logic clock;
    logic reset;
    logic swait;
    int   checks;
    int   errors;

    logic [31:0] ctrl_q;
    logic [31:0] div_q;
    logic [2:0]  alt_exp;

    bus_timer_arbiter_if #(.ADDRESS_WIDTH(1), .DATA_WIDTH(32)) bus ();

    bus_timer_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Timer slave model: control resets to 3, divisor to all ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ctrl_q <= 32'h3;
            div_q  <= 32'hffff_ffff;
        end else if (bus.slaveEnable && bus.slaveWrite && !bus.slaveWait) begin
            if (bus.slaveAddress == 1'b1) div_q  <= bus.slaveWriteData;
            else                          ctrl_q <= bus.slaveWriteData;
        end
    end

    assign bus.slaveReadData = (bus.slaveAddress == 1'b1) ? div_q : ctrl_q;
    assign bus.slaveWait     = swait;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        clock  = 1'b0;
        reset  = 1'b0;
        swait  = 1'b0;
        checks = 0;
        errors = 0;
        bus.m0Enable = 1'b0; bus.m0Write = 1'b0; bus.m0Address = 1'b0; bus.m0WriteData = '0;
        bus.m1Enable = 1'b0; bus.m1Write = 1'b0; bus.m1Address = 1'b0; bus.m1WriteData = '0;
`ifdef BUS_TIMER_ARBITER_LOCK_EN
        bus.m0Lock = 1'b0;
        bus.m1Lock = 1'b0;
`endif

        // Reset state
        repeat (10) @(negedge clock);
        #1;
        check("rst_m0wait", bus.m0Wait, 1);
        check("rst_m1wait", bus.m1Wait, 1);
        check("rst_slave_en", bus.slaveEnable, 0);
        check("rst_m0rdata", bus.m0ReadData, 0);
        check("rst_slave_addr", bus.slaveAddress, 0);

        // First m0 read of the divisor
        @(negedge clock);
        reset = 1'b1;
        bus.m0Enable = 1'b1; bus.m0Write = 1'b0; bus.m0Address = 1'b1;
        #1;
        check("idle_m0wait", bus.m0Wait, 1);
        check("idle_slave_en", bus.slaveEnable, 0);
        @(negedge clock); #1;
        check("rd1_slave_en", bus.slaveEnable, 1);
        check("rd1_m0wait", bus.m0Wait, 0);
        check("rd1_m0rdata", bus.m0ReadData, 32'hffff_ffff);
        check("rd1_m1wait", bus.m1Wait, 1);
        @(negedge clock);
        bus.m0Enable = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Tie after reset: m0 write first, then m1 read
        bus.m0Enable = 1'b1; bus.m0Write = 1'b1; bus.m0Address = 1'b1; bus.m0WriteData = 32'd1234;
        bus.m1Enable = 1'b1; bus.m1Write = 1'b0; bus.m1Address = 1'b0;
        #1;
        check("tie_idle_m1wait", bus.m1Wait, 1);
        @(negedge clock); #1;
        check("tie_wr_slave_wr", bus.slaveWrite, 1);
        check("tie_wr_wdata", bus.slaveWriteData, 32'd1234);
        check("tie_wr_m0wait", bus.m0Wait, 0);
        check("tie_wr_m1wait", bus.m1Wait, 1);
        check("tie_wr_m1rdata", bus.m1ReadData, 0);
        @(negedge clock);
        bus.m0Enable = 1'b0;
        #1;
        check("bubble_slave_en", bus.slaveEnable, 0);
        check("bubble_m1wait", bus.m1Wait, 1);
        @(negedge clock); #1;
        check("tie_rd_addr", bus.slaveAddress, 0);
        check("tie_rd_m1wait", bus.m1Wait, 0);
        check("tie_rd_m1rdata", bus.m1ReadData, 32'h3);
        check("tie_rd_m0wait", bus.m0Wait, 1);
        @(negedge clock);
        bus.m1Address = 1'b1;
        @(negedge clock); #1;
        check("readback_m1rdata", bus.m1ReadData, 32'd1234);
        check("readback_m1wait", bus.m1Wait, 0);

        // Slave wait stretched 3 cycles; m1 requests but is not owner
        @(negedge clock);
        bus.m0Enable = 1'b1; bus.m0Write = 1'b0; bus.m0Address = 1'b0;
        bus.m1Enable = 1'b1; bus.m1Write = 1'b0; bus.m1Address = 1'b1;
        swait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("wait_m0wait", bus.m0Wait, 1);
            check("wait_m1wait", bus.m1Wait, 1);
            check("wait_m1rdata", bus.m1ReadData, 0);
            check("wait_slave_en", bus.slaveEnable, 1);
        end
        @(negedge clock);
        swait = 1'b0;
        #1;
        check("wait_done_m0wait", bus.m0Wait, 0);
        check("wait_done_m0rdata", bus.m0ReadData, 32'h3);
        check("wait_done_m1wait", bus.m1Wait, 1);
        @(negedge clock);
        bus.m0Enable = 1'b0;
        bus.m1Enable = 1'b0;

        // Reset asserted mid-BUSY abandons the transfer
        @(negedge clock);
        bus.m1Enable = 1'b1; bus.m1Address = 1'b1;
        swait = 1'b1;
        @(negedge clock); #1;
        check("midrst_busy_en", bus.slaveEnable, 1);
        reset = 1'b0;
        @(negedge clock); #1;
        check("midrst_slave_en", bus.slaveEnable, 0);
        check("midrst_m1wait", bus.m1Wait, 1);
        reset = 1'b1;
        bus.m1Enable = 1'b0;
        swait = 1'b0;

        // Continuous contention: IDLE, 0, IDLE, 1, ... for 8 transactions
        @(negedge clock);
        bus.m0Enable = 1'b1; bus.m0Write = 1'b0; bus.m0Address = 1'b0;
        bus.m1Enable = 1'b1; bus.m1Write = 1'b0; bus.m1Address = 1'b1;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (k % 2 == 0)           alt_exp = 3'b011;
            else if ((k / 2) % 2 == 0) alt_exp = 3'b101;
            else                       alt_exp = 3'b110;
            check("alternate", {bus.slaveEnable, bus.m0Wait, bus.m1Wait}, alt_exp);
            @(negedge clock);
        end
        bus.m0Enable = 1'b0;
        bus.m1Enable = 1'b0;

        // m1 drops enable mid-BUSY; lastGrant stays with m0's grant
        bus.m0Enable = 1'b1; bus.m0Address = 1'b0;
        @(negedge clock); #1;
        check("solo_m0wait", bus.m0Wait, 0);
        @(negedge clock);
        bus.m0Enable = 1'b0;
        bus.m1Enable = 1'b1; bus.m1Address = 1'b0;
        swait = 1'b1;
        @(negedge clock); #1;
        check("drop_busy_en", bus.slaveEnable, 1);
        bus.m1Enable = 1'b0;
        #1;
        check("drop_slave_en", bus.slaveEnable, 0);
        check("drop_m1wait", bus.m1Wait, 1);
        @(negedge clock);
        swait = 1'b0;
        #1;
        check("drop_idle_en", bus.slaveEnable, 0);
        bus.m0Enable = 1'b1;
        bus.m1Enable = 1'b1;
        @(negedge clock); #1;
        check("drop_tie_m1wait", bus.m1Wait, 0);
        check("drop_tie_m0wait", bus.m0Wait, 1);
        @(negedge clock);
        bus.m0Enable = 1'b0;
        bus.m1Enable = 1'b0;

`ifdef BUS_TIMER_ARBITER_LOCK_EN
        // Locked read-modify-write of control by m1 while m0 keeps requesting
        bus.m1Enable = 1'b1; bus.m1Write = 1'b0; bus.m1Address = 1'b0; bus.m1Lock = 1'b1;
        @(negedge clock); #1;
        check("lock_rd_m1wait", bus.m1Wait, 0);
        check("lock_rd_m1rdata", bus.m1ReadData, 32'h3);
        bus.m0Enable = 1'b1; bus.m0Write = 1'b0; bus.m0Address = 1'b0;
        @(negedge clock); #1;
        check("locked_slave_en", bus.slaveEnable, 0);
        check("locked_m0wait", bus.m0Wait, 1);
        bus.m1Write = 1'b1; bus.m1WriteData = 32'h2; bus.m1Lock = 1'b0;
        @(negedge clock); #1;
        check("lock_wr_slave_wr", bus.slaveWrite, 1);
        check("lock_wr_m1wait", bus.m1Wait, 0);
        check("lock_wr_m0wait", bus.m0Wait, 1);
        @(negedge clock);
        bus.m1Enable = 1'b0;
        #1;
        check("unlock_idle_m0wait", bus.m0Wait, 1);
        @(negedge clock); #1;
        check("unlock_m0wait", bus.m0Wait, 0);
        check("unlock_ctrl_rdata", bus.m0ReadData, 32'h2);
        @(negedge clock);
        bus.m0Enable = 1'b0;
`endif

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
